// File: rtl/tof_cascade.sv
// ----------------------------------------------------------------------------
// tof_cascade
//
// Reversible-logic engine. A small program store holds DEPTH gate slots, each
// a multi-control Toffoli gate (control mask + target bit). An accepted
// operand is loaded into a working register. The active slots are then
// applied one per clock, in forward order or in reverse order. The result is
// offered on a valid/ready output.
//
// Because every gate is self-inverse, running the same program in reverse
// undoes a forward run.
//
// Build option:
//   TOF_CASCADE_REVERSE_EN  defined   -> in_dir selects forward/reverse order
//                           undefined -> in_dir is ignored, always forward
//
// Parameters:
//   WIDTH  working register width in bits (2..32)
//   DEPTH  number of gate slots in the program store (1..64)
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cfg_we/addr/ctrl/tgt  gate-slot write (only accepted while idle)
//   cfg_len_we/cfg_len    active program length (saturated to DEPTH)
//   busy                  high while running or holding a result
//   in_valid/in_ready     operand handshake; in_data operand, in_dir direction
//   out_valid/out_ready   result handshake; out_data result
// ----------------------------------------------------------------------------
module tof_cascade #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int TW   = $clog2(WIDTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_ctrl,
    input  logic [TW-1:0]    cfg_tgt,
    input  logic             cfg_len_we,
    input  logic [LW-1:0]    cfg_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Stored target is one bit wider than the port so it can also hold WIDTH,
    // the reset value that marks a slot as a no-op.
    localparam int  TSW      = $clog2(WIDTH + 1);
    localparam bit  ADDR_POW2 = ((1 << AW) == DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   work;
    logic               dir_q;
    logic [AW-1:0]      idx;
    logic [LW-1:0]      cnt;
    logic [LW-1:0]      len_q;
    logic [WIDTH-1:0]   ctrl_mem [DEPTH];
    logic [TSW-1:0]     tgt_mem  [DEPTH];

    // Direction actually used for an accepted operand.
    logic dir_eff;
`ifdef TOF_CASCADE_REVERSE_EN
    assign dir_eff = in_dir;
`else
    logic unused_in_dir;
    assign unused_in_dir = in_dir;
    assign dir_eff       = 1'b0;
`endif

    // Slot write is only legal for addresses inside the store.
    logic addr_ok;
    assign addr_ok = ADDR_POW2 || (int'(cfg_addr) < DEPTH);

    logic [LW-1:0] len_sat;
    assign len_sat = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;

    // ------------------------------------------------------------------
    // Gate evaluation for the slot currently addressed by idx.
    // The target bit is removed from the mask, so a mask that only names the
    // target degenerates into an unconditional NOT.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ctrl_cur;
    logic [TSW-1:0]   tgt_cur;
    logic             tgt_ok;
    logic [WIDTH-1:0] tbit;
    logic [WIDTH-1:0] mask_eff;
    logic             fire;
    logic [WIDTH-1:0] gated;

    always_comb begin
        ctrl_cur = ctrl_mem[idx];
        tgt_cur  = tgt_mem[idx];
        tgt_ok   = (int'(tgt_cur) < WIDTH);
        tbit     = tgt_ok ? (WIDTH'(1) << tgt_cur) : '0;
        mask_eff = ctrl_cur & ~tbit;
        fire     = tgt_ok && ((work & mask_eff) == mask_eff);
        gated    = fire ? (work ^ tbit) : work;
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                // cnt==0 is the empty program: spend one cycle, then finish.
                if (cnt <= LW'(1)) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data = work;

    // ------------------------------------------------------------------
    // State register, datapath and program store.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= IDLE;
            work  <= '0;
            dir_q <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
            len_q <= '0;
            // NOTE: the program store is reset explicitly because a freshly
            // reset engine must run no-op slots; this keeps it in flops.
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_mem[i] <= '0;
                tgt_mem[i]  <= TSW'(WIDTH);
            end
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (cfg_we && addr_ok) begin
                        ctrl_mem[cfg_addr] <= cfg_ctrl;
                        tgt_mem[cfg_addr]  <= TSW'(cfg_tgt);
                    end
                    if (cfg_len_we) len_q <= len_sat;
                    if (in_valid) begin
                        work  <= in_data;
                        dir_q <= dir_eff;
                        cnt   <= len_q;
                        // Reverse starts at the last active slot; the L=0
                        // wrap is harmless because no slot is applied then.
                        idx   <= dir_eff ? AW'(len_q - LW'(1)) : '0;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        work <= gated;
                        cnt  <= cnt - LW'(1);
                        idx  <= dir_q ? (idx - AW'(1)) : (idx + AW'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tof_cascade.sv
// ----------------------------------------------------------------------------
// tb_tof_cascade
//
// Directed bench for tof_cascade (WIDTH=8, DEPTH=16). Each step drives a
// hand-computed vector and compares data, latency and handshake state against
// constants written next to the stimulus.
// ----------------------------------------------------------------------------
module tb_tof_cascade;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [W-1:0] cfg_ctrl;
    logic [2:0]   cfg_tgt;
    logic         cfg_len_we;
    logic [4:0]   cfg_len;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_dir;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int errors = 0;
    int checks = 0;

    tof_cascade #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_ctrl   (cfg_ctrl),
        .cfg_tgt    (cfg_tgt),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dir     (in_dir),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    // Reverse of 0x00 through {01->b1, NOT b0, 06->b7}: slot2 idle, NOT b0
    // gives 0x01, slot0 then flips b1 -> 0x03. Forward-only builds give 0x01.
`ifdef TOF_CASCADE_REVERSE_EN
    localparam logic [W-1:0] REV_EXP = 8'h03;
`else
    localparam logic [W-1:0] REV_EXP = 8'h01;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; all sampling happens 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int a, input logic [W-1:0] c, input int t);
        cfg_we   = 1'b1;
        cfg_addr = a[3:0];
        cfg_ctrl = c;
        cfg_tgt  = t[2:0];
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic write_len(input int l);
        cfg_len_we = 1'b1;
        cfg_len    = l[4:0];
        tick();
        cfg_len_we = 1'b0;
    endtask

    task automatic start(input logic [W-1:0] d, input logic dir, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_dir   = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid, bounded.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_op(input string tag, input logic [W-1:0] exp);
        check({tag, " data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic op(input logic [W-1:0] d, input logic dir, input int lat,
                      input logic [W-1:0] exp, input string tag);
        start(d, dir, tag);
        wait_done(tag, lat);
        finish_op(tag, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_ctrl   = '0;
        cfg_tgt    = '0;
        cfg_len_we = 1'b0;
        cfg_len    = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_dir     = 1'b0;
        out_ready  = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst out_data",  32'(out_data),  32'd0);
        rst = 1'b0;
        tick();

        // Length 21 saturates to 16; reset slots are no-ops -> data unchanged,
        // latency 16+1.
        write_len(D + 5);
        op(8'h5A, 1'b0, D + 1, 8'h5A, "sat_len");

        // Two-control gate on bit 2.
        write_slot(0, 8'h03, 2);
        write_len(1);
        op(8'h03, 1'b0, 2, 8'h07, "and2_fire");
        op(8'h01, 1'b0, 2, 8'h01, "and2_hold");

        // Three-slot cascade. 0x03: slot0 flips b1 -> 0x01, NOT b0 -> 0x00,
        // slot2 needs b1&b2 -> 0x00.
        write_slot(0, 8'h01, 1);
        write_slot(1, 8'h00, 0);
        write_slot(2, 8'h06, 7);
        write_len(3);
        op(8'h03, 1'b0, 4, 8'h00, "casc_fwd");
        op(8'h00, 1'b1, 4, REV_EXP, "casc_rev");
        // 0x02: slot0 idle, NOT b0 -> 0x03, slot2 idle (b2=0).
        op(8'h02, 1'b0, 4, 8'h03, "casc_fwd2");

        // Back-pressure in DONE: result held, no accept of a new operand.
        start(8'h03, 1'b0, "stall");
        wait_done("stall", 4);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall out_data",  32'(out_data),  32'h00);
            check("stall in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("stall no_accept busy", 32'(busy),     32'd0);
        check("stall in_ready after", 32'(in_ready), 32'd1);

        // Config writes while running are ignored.
        start(8'h03, 1'b0, "cfg_busy");
        cfg_we     = 1'b1;
        cfg_addr   = 4'd1;
        cfg_ctrl   = 8'h00;
        cfg_tgt    = 3'd5;
        cfg_len_we = 1'b1;
        cfg_len    = 5'd1;
        tick();
        cfg_we     = 1'b0;
        cfg_len_we = 1'b0;
        wait_done("cfg_busy", 3);
        finish_op("cfg_busy", 8'h00);
        op(8'h03, 1'b0, 4, 8'h00, "cfg_busy_rerun");

        // Abort in the second RUN cycle.
        start(8'h03, 1'b0, "abort");
        tick();
        rst = 1'b1;
        #1;
        check("abort in_ready",  32'(in_ready),  32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort busy",      32'(busy),      32'd0);
        check("abort out_data",  32'(out_data),  32'd0);
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("abort no out_valid", 32'(seen), 32'd0);

        // Length cleared by reset: empty program, two-cycle latency.
        op(8'hA5, 1'b0, 2, 8'hA5, "len0");

        // Slots cleared by reset: three no-op slots.
        write_len(3);
        op(8'h3C, 1'b0, 4, 8'h3C, "rst_prog");

        // Mask naming only the target acts as an unconditional NOT.
        write_slot(0, 8'h80, 7);
        write_len(1);
        op(8'h00, 1'b0, 2, 8'h80, "self_mask_set");
        op(8'h80, 1'b0, 2, 8'h00, "self_mask_clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
